// File: rtl/sdpram_rr_arbiter.sv
// Two-master round-robin arbiter in front of a simple dual-port RAM (write port A, registered read port B).
// Define SDPRAM_ARB_RAW_FWD_EN to forward same-cycle write data to a colliding read.
module sdpram_rr_arbiter #(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [AddrBusWidth-1:0] m0_addr,
    input  logic [DataBusWidth-1:0] m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DataBusWidth-1:0] m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [AddrBusWidth-1:0] m1_addr,
    input  logic [DataBusWidth-1:0] m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DataBusWidth-1:0] m1_rdata,
    output logic                    ram_we_a,
    output logic [AddrBusWidth-1:0] ram_addr_a,
    output logic [DataBusWidth-1:0] ram_w_data_a,
    output logic                    ram_re_b,
    output logic [AddrBusWidth-1:0] ram_addr_b,
    input  logic [DataBusWidth-1:0] ram_r_data_b
);

    logic wr_c0, wr_c1, rd_c0, rd_c1;
    logic wr_g0, wr_g1, rd_g0, rd_g1;
    logic rr_wr, rr_rd;
    logic rd_pend, rd_owner;
    logic [DataBusWidth-1:0] resp_data;

    // Contenders are masked by reset so nothing is granted while rst_n is low.
    always_comb begin
        wr_c0 = rst_n & m0_req & m0_we;
        wr_c1 = rst_n & m1_req & m1_we;
        rd_c0 = rst_n & m0_req & ~m0_we;
        rd_c1 = rst_n & m1_req & ~m1_we;
        wr_g0 = wr_c0 & (~wr_c1 | ~rr_wr);
        wr_g1 = wr_c1 & (~wr_c0 | rr_wr);
        rd_g0 = rd_c0 & (~rd_c1 | ~rr_rd);
        rd_g1 = rd_c1 & (~rd_c0 | rr_rd);
    end

    assign m0_gnt = wr_g0 | rd_g0;
    assign m1_gnt = wr_g1 | rd_g1;

    always_comb begin
        ram_we_a     = wr_g0 | wr_g1;
        ram_addr_a   = '0;
        ram_w_data_a = '0;
        if (wr_g0) begin
            ram_addr_a   = m0_addr;
            ram_w_data_a = m0_wdata;
        end else if (wr_g1) begin
            ram_addr_a   = m1_addr;
            ram_w_data_a = m1_wdata;
        end
        ram_re_b   = rd_g0 | rd_g1;
        ram_addr_b = '0;
        if (rd_g0) begin
            ram_addr_b = m0_addr;
        end else if (rd_g1) begin
            ram_addr_b = m1_addr;
        end
    end

    // After each grant the pointer favours the master that just lost (or was idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_wr    <= 1'b0;
            rr_rd    <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (wr_g0 | wr_g1) begin
                rr_wr <= wr_g0;
            end
            if (rd_g0 | rd_g1) begin
                rr_rd    <= rd_g0;
                rd_owner <= rd_g1;
            end
            rd_pend <= rd_g0 | rd_g1;
        end
    end

`ifdef SDPRAM_ARB_RAW_FWD_EN
    logic                    fwd;
    logic [DataBusWidth-1:0] fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd <= ram_we_a & ram_re_b & (ram_addr_a == ram_addr_b);
            if (ram_we_a & ram_re_b & (ram_addr_a == ram_addr_b)) begin
                fwd_data <= ram_w_data_a;
            end
        end
    end

    assign resp_data = fwd ? fwd_data : ram_r_data_b;
`else
    assign resp_data = ram_r_data_b;
`endif

    assign m0_rvalid = rd_pend & ~rd_owner;
    assign m1_rvalid = rd_pend & rd_owner;
    assign m0_rdata  = m0_rvalid ? resp_data : '0;
    assign m1_rdata  = m1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_sdpram_rr_arbiter.sv
// Directed bench for sdpram_rr_arbiter with a behavioural 1-cycle-read RAM model on the RAM ports.
module tb_sdpram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we_a, ram_re_b;
    logic [31:0] ram_addr_a, ram_w_data_a, ram_addr_b;
    logic [31:0] ram_r_data_b = '0;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdpram_rr_arbiter #(.AddrBusWidth(32), .DataBusWidth(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_w_data_a(ram_w_data_a),
        .ram_re_b(ram_re_b), .ram_addr_b(ram_addr_b), .ram_r_data_b(ram_r_data_b)
    );

    // RAM model: read returns the pre-write contents when both ports hit one word.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            if (ram_re_b) ram_r_data_b <= mem[ram_addr_b[7:0]];
            if (ram_we_a) mem[ram_addr_a[7:0]] <= ram_w_data_a;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        cycle();
        pl_en   = 1'b0;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        logic expect_g0;
        logic [31:0] raw_exp;

        // Reset state, with a request pending to show grants are masked
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        check1("rst_m0_gnt", m0_gnt, 1'b0);
        check1("rst_ram_re_b", ram_re_b, 1'b0);
        check1("rst_ram_we_a", ram_we_a, 1'b0);
        check1("rst_m0_rvalid", m0_rvalid, 1'b0);
        check32("rst_m0_rdata", m0_rdata, 32'h0);
        idle();
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h00, 32'hA0A0A0A0);
        preload(8'h04, 32'hB1B1B1B1);
        preload(8'h30, 32'hCAFE0030);
        preload(8'h50, 32'h00000000);
        rst_n = 1'b1;
        cycle();

        // Single read by m0
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        check1("t1_m0_gnt", m0_gnt, 1'b1);
        check1("t1_m1_gnt", m1_gnt, 1'b0);
        check1("t1_ram_re_b", ram_re_b, 1'b1);
        check32("t1_ram_addr_b", ram_addr_b, 32'h10);
        cycle();
        idle();
        check1("t1_m0_rvalid", m0_rvalid, 1'b1);
        check32("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check1("t1_m1_rvalid", m1_rvalid, 1'b0);
        check32("t1_m1_rdata", m1_rdata, 32'h0);

        // Both masters reading continuously alternate from m0
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h00;
        m1_req = 1'b1; m1_addr = 32'h04;
        #1;
        for (int i = 0; i < 4; i++) begin
            expect_g0 = (i % 2 == 0);
            check1("t2_m0_gnt", m0_gnt, expect_g0);
            check1("t2_m1_gnt", m1_gnt, ~expect_g0);
            cycle();
            check1("t2_m0_rvalid", m0_rvalid, expect_g0);
            check1("t2_m1_rvalid", m1_rvalid, ~expect_g0);
            if (expect_g0) check32("t2_m0_rdata", m0_rdata, 32'hA0A0A0A0);
            else           check32("t2_m1_rdata", m1_rdata, 32'hB1B1B1B1);
        end
        idle();
        cycle();
        check1("t2_drain", m0_rvalid | m1_rvalid, 1'b0);

        // Concurrent write (m0) and read (m1)
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h11111111;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
        #1;
        check1("t3_m0_gnt", m0_gnt, 1'b1);
        check1("t3_m1_gnt", m1_gnt, 1'b1);
        check1("t3_ram_we_a", ram_we_a, 1'b1);
        check1("t3_ram_re_b", ram_re_b, 1'b1);
        check32("t3_ram_addr_a", ram_addr_a, 32'h20);
        check32("t3_ram_w_data_a", ram_w_data_a, 32'h11111111);
        check32("t3_ram_addr_b", ram_addr_b, 32'h30);
        cycle();
        idle();
        check1("t3_m1_rvalid", m1_rvalid, 1'b1);
        check32("t3_m1_rdata", m1_rdata, 32'hCAFE0030);
        check1("t3_m0_rvalid", m0_rvalid, 1'b0);

        // Two writers: m0 first, m1 held then granted
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h0000000A;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h0000000B;
        #1;
        check1("t4_m0_gnt", m0_gnt, 1'b1);
        check1("t4_m1_gnt_held", m1_gnt, 1'b0);
        check32("t4_addr_a_m0", ram_addr_a, 32'h40);
        check32("t4_wdata_m0", ram_w_data_a, 32'h0000000A);
        cycle();
        m0_req = 1'b0; m0_we = 1'b0;
        #1;
        check1("t4_m1_gnt", m1_gnt, 1'b1);
        check32("t4_addr_a_m1", ram_addr_a, 32'h44);
        check32("t4_wdata_m1", ram_w_data_a, 32'h0000000B);
        cycle();
        idle();
        m0_req = 1'b1; m0_addr = 32'h40;
        cycle();
        idle();
        check32("t4_rb_40", m0_rdata, 32'h0000000A);
        m1_req = 1'b1; m1_addr = 32'h44;
        cycle();
        idle();
        check32("t4_rb_44", m1_rdata, 32'h0000000B);

        // Same-address write and read in one cycle
`ifdef SDPRAM_ARB_RAW_FWD_EN
        raw_exp = 32'h12345678;
`else
        raw_exp = 32'h00000000;
`endif
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h50; m0_wdata = 32'h12345678;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h50;
        #1;
        check1("t5_both_gnt", m0_gnt & m1_gnt, 1'b1);
        cycle();
        idle();
        check1("t5_m1_rvalid", m1_rvalid, 1'b1);
        check32("t5_m1_rdata", m1_rdata, raw_exp);
        m1_req = 1'b1; m1_addr = 32'h50;
        cycle();
        idle();
        check32("t5_rb_50", m1_rdata, 32'h12345678);

        // Reset pulse between a read grant and its response
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        check1("t6_m0_gnt", m0_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        idle();
        #1;
        rst_n = 1'b1;
        cycle();
        check1("t6_m0_rvalid", m0_rvalid, 1'b0);
        check1("t6_m1_rvalid", m1_rvalid, 1'b0);
        check32("t6_m0_rdata", m0_rdata, 32'h0);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h60;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h64;
        #1;
        check1("t6_wr_ptr_m0", m0_gnt, 1'b1);
        check1("t6_wr_ptr_m1", m1_gnt, 1'b0);
        m0_we = 1'b0; m1_we = 1'b0;
        #1;
        check1("t6_rd_ptr_m0", m0_gnt, 1'b1);
        check1("t6_rd_ptr_m1", m1_gnt, 1'b0);
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdpram_rr_arbiter.md
Name: sdpram_rr_arbiter

Overview:
Shares one simple dual-port RAM (write port A, read port B, 1-cycle registered read) between two masters, e.g. instruction fetch (m0) and load/store unit (m1).
- Arbitrates writes onto port A and reads onto port B independently, each with its own round-robin pointer.
- Tracks the owner of each in-flight read and routes the returned data to that master one cycle later.
- Sits directly in front of the RAM instance inside the memory subsystem.

Parameters:
AddrBusWidth, 32, address width of masters and RAM ports
DataBusWidth, 32, data width of masters and RAM ports

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request valid
m0_we  in  1  master 0 request is a write (1) or read (0)
m0_addr  in  AddrBusWidth  master 0 address
m0_wdata  in  DataBusWidth  master 0 write data
m0_gnt  out  1  master 0 request accepted this cycle (combinational)
m0_rvalid  out  1  master 0 read data valid (registered)
m0_rdata  out  DataBusWidth  master 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for master 1
ram_we_a  out  1  RAM port A write enable
ram_addr_a  out  AddrBusWidth  RAM port A address
ram_w_data_a  out  DataBusWidth  RAM port A write data
ram_re_b  out  1  RAM port B read enable
ram_addr_b  out  AddrBusWidth  RAM port B address
ram_r_data_b  in  DataBusWidth  RAM port B read data, valid the cycle after ram_re_b

Behaviour:
- Write contenders: masters with req&we. Read contenders: masters with req&!we. The two classes are arbitrated separately, so one read and one write are granted in the same cycle when they come from different masters.
- Single contender in a class: granted immediately, gnt=1 in the same cycle.
- Two contenders in a class: the master named by that class's pointer (rr_wr, rr_rd) wins. The loser sees gnt=0 and must hold req/we/addr/wdata stable until granted.
- Pointer update on every grant in a class: the pointer moves to the master that did not win. With no grant, the pointer holds. Reset value of both pointers: 0 (master 0 first).
- Port A: ram_we_a=1 iff a write is granted; addr and wdata muxed from the winner. When idle, addr and wdata drive 0.
- Port B: ram_re_b=1 iff a read is granted; addr muxed from the winner, 0 when idle.
- Read response: on a granted read in cycle N, register rd_pend=1 and rd_owner=winner. In cycle N+1, owner's rvalid=1 and rdata=ram_r_data_b; the other master has rvalid=0 and rdata=0.
- Reads are fully pipelined: back-to-back grants give rvalid on consecutive cycles. No response backpressure; masters must accept rvalid.
- Latency: read request to rvalid = 1 cycle. Write completes in the grant cycle.
- Reset (async assert, sync release): rd_pend=0, rd_owner=0, pointers=0, all rvalid=0, all rdata=0. Combinational outputs follow inputs while out of reset. During reset: all gnt=0, ram_we_a=0, ram_re_b=0.
- Reset mid-read: the pending response is dropped and no rvalid is produced after release.
- Same-cycle write and read to equal addresses (full AddrBusWidth compare) by different masters: see Optional Feature.

Optional Feature:
Macro SDPRAM_ARB_RAW_FWD_EN.
- Defined: when a granted write and a granted read in the same cycle have equal addresses, register the write data and a fwd flag. Next cycle, rdata returns the registered write data instead of ram_r_data_b. fwd clears on reset.
- Undefined: rdata always equals ram_r_data_b, so the read returns the pre-write (old) RAM contents.

Test Plan:
- m0 read 0x10 alone, RAM word 0x10 = 0xDEADBEEF -> m0_gnt=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- m0 and m1 both read continuously for 4 cycles after reset -> grants alternate m0,m1,m0,m1; each gets rvalid 1 cycle after its grant with the correct word.
- m0 write 0x20←0x11111111 and m1 read 0x30 in the same cycle -> both gnt=1; ram_we_a and ram_re_b both 1; m1_rvalid next cycle.
- Both masters write the same cycle (m0 0x40←0xA, m1 0x44←0xB), pointer=0 -> m0 granted first, m1 held and granted next cycle; both words are in RAM afterwards.
- m0 write 0x50←0x12345678 with m1 read 0x50 (old 0x0) -> with SDPRAM_ARB_RAW_FWD_EN m1_rdata=0x12345678, without it 0x0.
- Read granted, then rst_n pulsed low before the next edge -> no rvalid after release; pointers back to 0.
